// File: rtl/garble_table_gen.sv
// Garbler-side table generator for one 2-input AND gate: drives an external hash core
// once per input-label combination and streams the four masked rows out over valid/ready.
module garble_table_gen #(
  parameter int LABEL_W = 80,
  parameter int GID_W   = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [LABEL_W-1:0] a0,
  input  logic [LABEL_W-1:0] a1,
  input  logic [LABEL_W-1:0] b0,
  input  logic [LABEL_W-1:0] b1,
  input  logic [LABEL_W-1:0] c0,
  input  logic [LABEL_W-1:0] c1,
  input  logic [GID_W-1:0]   gid,
  output logic               busy,
  output logic               done,
  output logic               row_valid,
  input  logic               row_ready,
  output logic [LABEL_W-1:0] row_data,
  output logic [1:0]         row_pos,
  output logic               hash_kpq_valid,
  output logic [LABEL_W-1:0] hash_kp,
  output logic [LABEL_W-1:0] hash_kq,
  output logic [GID_W-1:0]   hash_gid,
  input  logic               hash_ready,
  input  logic [LABEL_W-1:0] hash_digest_80,
  input  logic               hash_digest_valid
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_OUT,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [1:0]         r_q, r_d;
  logic [LABEL_W-1:0] a0_q, a0_d;
  logic [LABEL_W-1:0] a1_q, a1_d;
  logic [LABEL_W-1:0] b0_q, b0_d;
  logic [LABEL_W-1:0] b1_q, b1_d;
  logic [LABEL_W-1:0] c0_q, c0_d;
  logic [LABEL_W-1:0] c1_q, c1_d;
  logic [GID_W-1:0]   gid_q, gid_d;
  logic [LABEL_W-1:0] row_data_q, row_data_d;
  logic [1:0]         row_pos_q, row_pos_d;

  logic [LABEL_W-1:0] kp;
  logic [LABEL_W-1:0] kq;
  logic [LABEL_W-1:0] c_sel;

  // Operands depend only on captured labels and r, so they hold steady through REQ and WAIT.
  always_comb begin
    kp    = r_q[1] ? a1_q : a0_q;
    kq    = r_q[0] ? b1_q : b0_q;
    c_sel = (r_q[1] & r_q[0]) ? c1_q : c0_q;
  end

  always_comb begin
    state_d    = state_q;
    r_d        = r_q;
    a0_d       = a0_q;
    a1_d       = a1_q;
    b0_d       = b0_q;
    b1_d       = b1_q;
    c0_d       = c0_q;
    c1_d       = c1_q;
    gid_d      = gid_q;
    row_data_d = row_data_q;
    row_pos_d  = row_pos_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          a0_d    = a0;
          a1_d    = a1;
          b0_d    = b0;
          b1_d    = b1;
          c0_d    = c0;
          c1_d    = c1;
          gid_d   = gid;
          r_d     = 2'd0;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (hash_ready) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // The core drops digest_valid on the accepting edge, so anything seen here is fresh.
        if (hash_digest_valid) begin
          row_data_d = hash_digest_80 ^ c_sel;
          row_pos_d  = {kp[0], kq[0]};
          state_d    = S_OUT;
        end
      end
      S_OUT: begin
        if (row_ready) begin
          if (r_q == 2'd3) begin
            state_d = S_DONE;
          end else begin
            r_d     = r_q + 2'd1;
            state_d = S_REQ;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Reset also clears the captured labels so the hash operand outputs read back as zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      r_q        <= '0;
      a0_q       <= '0;
      a1_q       <= '0;
      b0_q       <= '0;
      b1_q       <= '0;
      c0_q       <= '0;
      c1_q       <= '0;
      gid_q      <= '0;
      row_data_q <= '0;
      row_pos_q  <= '0;
    end else begin
      state_q    <= state_d;
      r_q        <= r_d;
      a0_q       <= a0_d;
      a1_q       <= a1_d;
      b0_q       <= b0_d;
      b1_q       <= b1_d;
      c0_q       <= c0_d;
      c1_q       <= c1_d;
      gid_q      <= gid_d;
      row_data_q <= row_data_d;
      row_pos_q  <= row_pos_d;
    end
  end

  assign busy           = (state_q != S_IDLE);
  assign done           = (state_q == S_DONE);
  assign row_valid      = (state_q == S_OUT);
  assign row_data       = row_data_q;
  assign row_pos        = row_pos_q;
  assign hash_kpq_valid = (state_q == S_REQ) && hash_ready;
  assign hash_kp        = kp;
  assign hash_kq        = kq;
  assign hash_gid       = gid_q;

endmodule

// File: tb/tb_garble_table_gen.sv
// Self-checking bench for garble_table_gen: a fixed-latency hash stub plus a truth-table
// model of the garbled AND gate, with directed scenarios and randomized labels.
module tb_garble_table_gen;

  localparam int LABEL_W = 80;
  localparam int GID_W   = 64;
  localparam int HASH_LAT = 82;

  typedef struct {
    logic [LABEL_W-1:0] a0, a1, b0, b1, c0, c1;
    logic [GID_W-1:0]   gid;
  } gate_t;

  typedef struct {
    logic [LABEL_W-1:0] data;
    logic [1:0]         pos;
  } row_t;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               start = 1'b0;
  logic [LABEL_W-1:0] a0 = '0, a1 = '0, b0 = '0, b1 = '0, c0 = '0, c1 = '0;
  logic [GID_W-1:0]   gid = '0;
  logic               busy, done, row_valid;
  logic               row_ready = 1'b1;
  logic [LABEL_W-1:0] row_data;
  logic [1:0]         row_pos;
  logic               hash_kpq_valid;
  logic [LABEL_W-1:0] hash_kp, hash_kq;
  logic [GID_W-1:0]   hash_gid;
  logic               hash_ready;
  logic [LABEL_W-1:0] hash_digest_80 = '0;
  logic               hash_digest_valid = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  garble_table_gen #(.LABEL_W(LABEL_W), .GID_W(GID_W)) dut (
    .clk(clk), .reset(reset), .start(start),
    .a0(a0), .a1(a1), .b0(b0), .b1(b1), .c0(c0), .c1(c1), .gid(gid),
    .busy(busy), .done(done),
    .row_valid(row_valid), .row_ready(row_ready), .row_data(row_data), .row_pos(row_pos),
    .hash_kpq_valid(hash_kpq_valid), .hash_kp(hash_kp), .hash_kq(hash_kq),
    .hash_gid(hash_gid), .hash_ready(hash_ready),
    .hash_digest_80(hash_digest_80), .hash_digest_valid(hash_digest_valid)
  );

  always #5 clk = ~clk;

  // Hash core stand-in: digest valid exactly HASH_LAT edges after the accepting edge.
  logic stub_busy = 1'b0;
  logic force_not_ready = 1'b0;
  int   stub_cnt = 0;
  assign hash_ready = !stub_busy && !force_not_ready;

  always @(posedge clk) begin
    if (hash_kpq_valid && hash_ready) begin
      stub_busy         <= 1'b1;
      stub_cnt          <= 1;
      hash_digest_valid <= 1'b0;
      hash_digest_80    <= hash_kp ^ hash_kq ^ {hash_gid, 16'h0};
    end else if (stub_busy) begin
      if (stub_cnt == HASH_LAT) begin
        stub_busy         <= 1'b0;
        hash_digest_valid <= 1'b1;
      end else begin
        stub_cnt <= stub_cnt + 1;
      end
    end
  end

  // Observation: counters and accepted rows, sampled on the falling edge.
  int   cyc = 0;
  int   done_cnt = 0;
  int   kpq_cnt = 0;
  int   req_at = 0;
  int   last_lat = 0;
  logic prev_rv = 1'b0;
  row_t rows[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (hash_kpq_valid) kpq_cnt++;
    if (hash_kpq_valid && hash_ready) req_at = cyc + 1;
    if (row_valid && !prev_rv) last_lat = cyc - req_at;
    prev_rv = row_valid;
    if (row_valid && row_ready) rows.push_back('{row_data, row_pos});
  end

  function automatic logic [LABEL_W-1:0] randLabel();
    logic [95:0] t;
    t = {$urandom(), $urandom(), $urandom()};
    return t[LABEL_W-1:0];
  endfunction

  function automatic gate_t randGate();
    gate_t g;
    g.a0 = randLabel(); g.a1 = randLabel();
    g.b0 = randLabel(); g.b1 = randLabel();
    g.c0 = randLabel(); g.c1 = randLabel();
    g.gid = {$urandom(), $urandom()};
    return g;
  endfunction

  // Garbled AND table: one row per input truth assignment (x,y), masking the label of x&y.
  function automatic void modelTable(input gate_t g, output row_t exp[4]);
    logic [LABEL_W-1:0] ka, kb, cout;
    for (int x = 0; x < 2; x++) begin
      for (int y = 0; y < 2; y++) begin
        ka   = (x == 1) ? g.a1 : g.a0;
        kb   = (y == 1) ? g.b1 : g.b0;
        cout = (x == 1 && y == 1) ? g.c1 : g.c0;
        exp[2*x+y].data = (ka ^ kb ^ {g.gid, 16'h0}) ^ cout;
        exp[2*x+y].pos  = {ka[0], kb[0]};
      end
    end
  endfunction

  task automatic checkOutput(input string tag, input logic [LABEL_W-1:0] obs,
                             input logic [LABEL_W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input gate_t g);
    a0 = g.a0; a1 = g.a1; b0 = g.b0; b1 = g.b1; c0 = g.c0; c1 = g.c1; gid = g.gid;
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_busy"}, 80'(busy), 80'(0));
    checkOutput({tag, "_done"}, 80'(done), 80'(0));
    checkOutput({tag, "_row_valid"}, 80'(row_valid), 80'(0));
    checkOutput({tag, "_kpq_valid"}, 80'(hash_kpq_valid), 80'(0));
    checkOutput({tag, "_row_data"}, row_data, 80'(0));
    checkOutput({tag, "_row_pos"}, 80'(row_pos), 80'(0));
    checkOutput({tag, "_hash_kp"}, hash_kp, 80'(0));
    checkOutput({tag, "_hash_kq"}, hash_kq, 80'(0));
    checkOutput({tag, "_hash_gid"}, 80'(hash_gid), 80'(0));
  endtask

  task automatic waitRows(input int n);
    for (int i = 0; i < 1000 && rows.size() < n; i++) tick(1);
    checkOutput("rows_arrive", 80'(rows.size() >= n), 80'(1));
  endtask

  task automatic waitDone(input int base, input string tag);
    for (int i = 0; i < 2000 && done_cnt == base; i++) tick(1);
    checkOutput({tag, "_done_seen"}, 80'(done_cnt != base), 80'(1));
    tick(2);
    checkOutput({tag, "_done_once"}, 80'(done_cnt - base), 80'(1));
  endtask

  task automatic compareRows(input string tag, input gate_t g);
    row_t exp[4];
    modelTable(g, exp);
    checkOutput({tag, "_row_count"}, 80'(rows.size()), 80'(4));
    for (int i = 0; i < 4 && i < rows.size(); i++) begin
      checkOutput($sformatf("%s_data%0d", tag, i), rows[i].data, exp[i].data);
      checkOutput($sformatf("%s_pos%0d", tag, i), 80'(rows[i].pos), 80'(exp[i].pos));
    end
  endtask

  task automatic runGate(input gate_t g, input string tag);
    int base;
    rows.delete();
    base = done_cnt;
    applyStimulus(g);
    waitDone(base, tag);
    compareRows(tag, g);
  endtask

  initial begin
    gate_t g_basic, g1, g2, g;
    int    base, kbase, hi_cnt;
    logic  stable;
    logic [LABEL_W-1:0] held_data;
    logic [1:0] held_pos;
    int    exp_perm[4];

    g_basic.a0 = 80'h10;  g_basic.a1 = 80'h21;
    g_basic.b0 = 80'h40;  g_basic.b1 = 80'h81;
    g_basic.c0 = 80'hA00; g_basic.c1 = 80'hB00;
    g_basic.gid = '0;

    tick(3);
    reset = 1'b0;
    checkIdle("reset");

    // Basic gate, fixed labels: rows 0..2 cross-checked against hand-computed constants too.
    kbase = kpq_cnt;
    runGate(g_basic, "basic");
    if (rows.size() >= 3) begin
      checkOutput("basic_const0", rows[0].data, 80'hA50);
      checkOutput("basic_const1", rows[1].data, 80'hA91);
      checkOutput("basic_const2", rows[2].data, 80'hA61);
    end
    checkOutput("basic_latency", 80'(last_lat), 80'(HASH_LAT + 1));
    checkOutput("basic_req_pulses", 80'(kpq_cnt - kbase), 80'(4));
    checkOutput("basic_idle_busy", 80'(busy), 80'(0));

    // Backpressure on row 2.
    rows.delete();
    base = done_cnt;
    applyStimulus(g_basic);
    waitRows(2);
    row_ready = 1'b0;
    for (int i = 0; i < 300 && !row_valid; i++) tick(1);
    checkOutput("bp_row_present", 80'(row_valid), 80'(1));
    held_data = row_data;
    held_pos  = row_pos;
    kbase     = kpq_cnt;
    stable    = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (row_data !== held_data || row_pos !== held_pos || row_valid !== 1'b1) stable = 1'b0;
    end
    checkOutput("bp_row_stable", 80'(stable), 80'(1));
    checkOutput("bp_no_request", 80'(kpq_cnt - kbase), 80'(0));
    row_ready = 1'b1;
    waitDone(base, "bp");
    compareRows("bp", g_basic);

    // Hash core not ready for 20 cycles after start.
    g = randGate();
    rows.delete();
    base = done_cnt;
    kbase = kpq_cnt;
    force_not_ready = 1'b1;
    applyStimulus(g);
    hi_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (hash_kpq_valid) hi_cnt++;
      tick(1);
    end
    checkOutput("nr_no_request", 80'(hi_cnt), 80'(0));
    force_not_ready = 1'b0;
    #1;
    checkOutput("nr_req_valid", 80'(hash_kpq_valid), 80'(1));
    checkOutput("nr_req_kp", hash_kp, g.a0);
    checkOutput("nr_req_kq", hash_kq, g.b0);
    checkOutput("nr_req_gid", 80'(hash_gid), 80'(g.gid));
    tick(1);
    checkOutput("nr_req_one_cycle", 80'(hash_kpq_valid), 80'(0));
    waitDone(base, "nr");
    compareRows("nr", g);
    checkOutput("nr_req_pulses", 80'(kpq_cnt - kbase), 80'(4));

    // Start while busy is ignored.
    g1 = randGate();
    g2 = randGate();
    rows.delete();
    base = done_cnt;
    applyStimulus(g1);
    waitRows(1);
    tick(20);
    applyStimulus(g2);
    waitDone(base, "busy_start");
    compareRows("busy_start", g1);
    tick(5);
    checkOutput("busy_start_no_second", 80'(busy), 80'(0));
    checkOutput("busy_start_row_total", 80'(rows.size()), 80'(4));

    // Reset during row 2 WAIT, then a fresh gate after the stub leaves a stale digest.
    g = randGate();
    rows.delete();
    applyStimulus(g);
    waitRows(2);
    tick(20);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    checkIdle("midreset");
    tick(100);
    checkIdle("midreset_late");
    g = randGate();
    runGate(g, "after_reset");

    // Point-and-permute with inverted a-label LSBs.
    g = randGate();
    g.a0[0] = 1'b1; g.a1[0] = 1'b0; g.b0[0] = 1'b0; g.b1[0] = 1'b1;
    runGate(g, "perm");
    exp_perm = '{2, 3, 0, 1};
    for (int i = 0; i < 4 && i < rows.size(); i++)
      checkOutput($sformatf("perm_seq%0d", i), 80'(rows[i].pos), 80'(exp_perm[i]));

    // Randomized gates.
    for (int k = 0; k < 4; k++) begin
      g = randGate();
      runGate(g, $sformatf("rand%0d", k));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
